// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types and defaults for the joystick ADC scan scheduler.
package adc_scan_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        START,
        WAIT
    } scanState_t;

    localparam int NUM_CH_DEF      = 4;
    localparam int DATA_W_DEF      = 4;
    localparam int SETTLE_CYC_DEF  = 32;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Stick channel numbering as seen on the analog mux.
    typedef enum int {
        CH_P1X = 0,
        CH_P1Y = 1,
        CH_P2X = 2,
        CH_P2Y = 3
    } stickChannel_t;

    // Select width that stays legal for a single-channel build.
    function automatic int selWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One counter serves both SETTLE and WAIT, so size it for the longer of the two.
    function automatic int counterWidth(input int settleCyc, input int timeoutCyc);
        int longest;
        longest = (settleCyc > timeoutCyc) ? settleCyc : timeoutCyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// ADC handshake bundle: mux select and start towards the converter, result and done back.
interface adc_scan_scheduler_if
    import adc_scan_scheduler_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int SEL_W = selWidth(NUM_CH);

    logic [SEL_W-1:0]  adc_sel;
    logic              adc_start;
    logic [DATA_W-1:0] adc_data;
    logic              adc_done;

    modport master (
        output adc_sel,
        output adc_start,
        input  adc_data,
        input  adc_done
    );

    modport slave (
        input  adc_sel,
        input  adc_start,
        output adc_data,
        output adc_done
    );

endinterface

// File: rtl/adc_scan_scheduler_rr_next_enabled.sv
// Round-robin search for the next enabled channel starting at ptr (wrapping).
// isLast reports that no enabled channel sits above the chosen one, i.e. the
// chosen channel closes the current pass.
module rr_next_enabled
    import adc_scan_scheduler_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    localparam int SEL_W = selWidth(NUM_CH)
) (
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] enable,
    output logic [SEL_W-1:0]  idx,
    output logic              found,
    output logic              isLast
);

    // First enabled channel at or after ptr, then check for any enabled channel above it.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        isLast = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && enable[(int'(ptr) + i) % NUM_CH]) begin
                found = 1'b1;
                idx   = SEL_W'((int'(ptr) + i) % NUM_CH);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (found && enable[j] && (j > int'(idx))) begin
                isLast = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Sequences the shared joystick ADC over the enabled stick channels:
// select mux, settle, pulse start, then capture the result or give up on timeout.
module adc_scan_scheduler
    import adc_scan_scheduler_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     fastClock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     err_clr,
    adc_scan_scheduler_if.master     adcBus,
    output logic [NUM_CH*DATA_W-1:0] results,
    output logic [NUM_CH-1:0]        result_valid,
    output logic                     scan_done,
    output logic                     timeout_err
);

    localparam int SEL_W = selWidth(NUM_CH);
    localparam int CNT_W = counterWidth(SETTLE_CYC, TIMEOUT_CYC);

    scanState_t              state, stateNext;
    logic [CNT_W-1:0]        cnt, cntNext;
    logic [SEL_W-1:0]        ptr, ptrNext;
    logic [SEL_W-1:0]        adcSel, selNext;
    logic                    adcStart, startNext;
    logic                    curLast, curLastNext;
    logic [NUM_CH*DATA_W-1:0] resultsNext;
    logic [NUM_CH-1:0]       validNext;
    logic                    scanDoneNext;
    logic                    errNext;
    logic                    finishCh;

    logic [SEL_W-1:0]        pickIdx;
    logic                    pickFound;
    logic                    pickIsLast;

    rr_next_enabled #(
        .NUM_CH (NUM_CH)
    ) pick (
        .ptr    (ptr),
        .enable (ch_enable),
        .idx    (pickIdx),
        .found  (pickFound),
        .isLast (pickIsLast)
    );

    assign adcBus.adc_sel   = adcSel;
    assign adcBus.adc_start = adcStart;

    // Next-state and next-output decode; adc_sel holds the in-flight channel for the whole conversion.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        ptrNext      = ptr;
        selNext      = adcSel;
        startNext    = 1'b0;
        curLastNext  = curLast;
        resultsNext  = results;
        validNext    = result_valid;
        scanDoneNext = 1'b0;
        errNext      = timeout_err & ~err_clr;
        finishCh     = 1'b0;

        case (state)
            IDLE: begin
                if (pickFound) begin
                    stateNext   = SETTLE;
                    selNext     = pickIdx;
                    cntNext     = '0;
                    curLastNext = pickIsLast;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    stateNext = START;
                    startNext = 1'b1;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            START: begin
                stateNext = WAIT;
                cntNext   = '0;
            end
            WAIT: begin
                if (adcBus.adc_done) begin
                    resultsNext[adcSel*DATA_W +: DATA_W] = adcBus.adc_data;
                    validNext[adcSel] = 1'b1;
                    finishCh = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // A timeout in the same cycle as err_clr must still leave the flag set.
                    errNext           = 1'b1;
                    validNext[adcSel] = 1'b0;
                    finishCh          = 1'b1;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (finishCh) begin
            stateNext    = IDLE;
            ptrNext      = (adcSel == SEL_W'(NUM_CH - 1)) ? '0 : adcSel + 1'b1;
            scanDoneNext = curLast;
        end
    end

    // State and registered outputs; reset drops everything including any start pulse.
    always_ff @(posedge fastClock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= '0;
            adcSel       <= '0;
            adcStart     <= 1'b0;
            curLast      <= 1'b0;
            results      <= '0;
            result_valid <= '0;
            scan_done    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= stateNext;
            cnt          <= cntNext;
            ptr          <= ptrNext;
            adcSel       <= selNext;
            adcStart     <= startNext;
            curLast      <= curLastNext;
            results      <= resultsNext;
            result_valid <= validNext;
            scan_done    <= scanDoneNext;
            timeout_err  <= errNext;
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: the bench plays the ADC and tracks expected
// results, valid bits, error flag and scan order from the channel rules.
module tb_adc_scan_scheduler;
    import adc_scan_scheduler_pkg::*;

    localparam int NCH    = 4;
    localparam int DW     = 4;
    localparam int SETTLE = 32;
    localparam int TMO    = 255;

    logic        fastClock = 1'b0;
    logic        reset     = 1'b1;
    logic [3:0]  ch_enable = 4'h0;
    logic        err_clr   = 1'b0;
    logic [15:0] results;
    logic [3:0]  result_valid;
    logic        scan_done;
    logic        timeout_err;

    adc_scan_scheduler_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

    adc_scan_scheduler #(
        .NUM_CH      (NCH),
        .DATA_W      (DW),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .fastClock    (fastClock),
        .reset        (reset),
        .ch_enable    (ch_enable),
        .err_clr      (err_clr),
        .adcBus       (bus),
        .results      (results),
        .result_valid (result_valid),
        .scan_done    (scan_done),
        .timeout_err  (timeout_err)
    );

    always #5 fastClock = ~fastClock;

    typedef struct {
        logic [3:0] en;
        int         ch;
        int         delay;
        int         hold;
        logic [3:0] data;
        bit         never;
        bit         lastInPass;
    } vec_t;

    vec_t tbl[14];

    int nChecks = 0;
    int nFails  = 0;

    int cyc = 0;
    int selChangeCyc = 0;
    int lastSel = 0;
    int nStartSeen = 0;
    int nScanSeen = 0;
    int expStarts = 0;
    int expScanDone = 0;
    int lastFinishCyc = 0;
    bit gapValid = 1'b0;
    int prevCh = 0;

    logic [3:0] modRes[NCH];
    logic [3:0] modValid;
    logic       modErr;
    int         modPtr;

    // Cycle counter and event monitor sampled just after each rising edge.
    initial begin
        forever begin
            @(posedge fastClock);
            #1;
            cyc++;
            if (int'(bus.adc_sel) != lastSel) begin
                lastSel = int'(bus.adc_sel);
                selChangeCyc = cyc;
            end
            if (scan_done === 1'b1) nScanSeen++;
            if (bus.adc_start === 1'b1) nStartSeen++;
        end
    end

    // Hard stop in case some wait is never satisfied.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int modelNext(input int ptr, input logic [3:0] en);
        for (int i = 0; i < NCH; i++) begin
            if (en[(ptr + i) % NCH]) return (ptr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic bit modelIsLast(input int c, input logic [3:0] en);
        return (int'(en) >> (c + 1)) == 0;
    endfunction

    function automatic logic [15:0] packRes();
        logic [15:0] r;
        for (int c = 0; c < NCH; c++) r[c*DW +: DW] = modRes[c];
        return r;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NCH; c++) modRes[c] = 4'h0;
        modValid = 4'h0;
        modErr   = 1'b0;
        modPtr   = 0;
    endtask

    // One conversion, called at a falling edge while the scheduler is idle or settling.
    task automatic convert(input string tag, input int expCh, input int delay, input int hold,
                           input logic [3:0] data, input bit never, input bit clrAtTimeout,
                           input bit expDone);
        int waited;
        int startCyc;
        waited = 0;
        while (bus.adc_start !== 1'b1 && waited < 600) begin
            @(negedge fastClock);
            waited++;
        end
        check($sformatf("%s/start_seen", tag), {31'd0, bus.adc_start}, 32'd1);
        if (bus.adc_start !== 1'b1) return;
        expStarts++;
        startCyc = cyc;
        check($sformatf("%s/sel", tag), 32'(bus.adc_sel), 32'(expCh));
        if (expCh != prevCh)
            check($sformatf("%s/settle_len", tag), 32'(startCyc - selChangeCyc), 32'(SETTLE));
        if (gapValid)
            check($sformatf("%s/done_to_start", tag), 32'(startCyc - lastFinishCyc), 32'(SETTLE + 2));
        prevCh = expCh;
        @(negedge fastClock);
        check($sformatf("%s/start_width", tag), {31'd0, bus.adc_start}, 32'd0);
        if (never) begin
            repeat (TMO - 1) @(negedge fastClock);
            check($sformatf("%s/err_not_early", tag), {31'd0, timeout_err}, {31'd0, modErr});
            lastFinishCyc = cyc;
            if (clrAtTimeout) err_clr = 1'b1;
            @(negedge fastClock);
            err_clr = 1'b0;
            modErr = 1'b1;
            modValid[expCh] = 1'b0;
        end else begin
            repeat (delay - 1) @(negedge fastClock);
            bus.adc_data = data;
            bus.adc_done = 1'b1;
            lastFinishCyc = cyc;
            @(negedge fastClock);
            modRes[expCh] = data;
            modValid[expCh] = 1'b1;
            if (hold <= 1) bus.adc_done = 1'b0;
            else bus.adc_data = ~data;
        end
        modPtr = (expCh + 1) % NCH;
        if (expDone) expScanDone++;
        check($sformatf("%s/results", tag), 32'(results), 32'(packRes()));
        check($sformatf("%s/valid", tag), 32'(result_valid), 32'(modValid));
        check($sformatf("%s/timeout_err", tag), {31'd0, timeout_err}, {31'd0, modErr});
        check($sformatf("%s/scan_done", tag), {31'd0, scan_done}, {31'd0, expDone});
        if (!never && hold > 1) begin
            repeat (hold - 1) @(negedge fastClock);
            bus.adc_done = 1'b0;
            bus.adc_data = 4'h0;
        end
        gapValid = 1'b1;
    endtask

    initial begin
        int ch;
        int startsBefore;
        int waited;
        bit nv;
        int dl;

        tbl[0]  = '{4'hF, CH_P1X, 3,   1, 4'h5, 1'b0, 1'b0};
        tbl[1]  = '{4'hF, CH_P1Y, 3,   5, 4'h6, 1'b0, 1'b0};
        tbl[2]  = '{4'hF, CH_P2X, 3,   1, 4'h7, 1'b0, 1'b0};
        tbl[3]  = '{4'hF, CH_P2Y, 3,   1, 4'h8, 1'b0, 1'b1};
        tbl[4]  = '{4'hF, CH_P1X, 3,   1, 4'h5, 1'b0, 1'b0};
        tbl[5]  = '{4'hA, CH_P1Y, 3,   1, 4'h9, 1'b0, 1'b0};
        tbl[6]  = '{4'hA, CH_P2Y, 5,   1, 4'h4, 1'b0, 1'b1};
        tbl[7]  = '{4'hA, CH_P1Y, 1,   1, 4'h2, 1'b0, 1'b0};
        tbl[8]  = '{4'hA, CH_P2Y, 255, 1, 4'hC, 1'b0, 1'b1};
        tbl[9]  = '{4'hF, CH_P1X, 2,   1, 4'h3, 1'b0, 1'b0};
        tbl[10] = '{4'hF, CH_P1Y, 4,   1, 4'hA, 1'b0, 1'b0};
        tbl[11] = '{4'hF, CH_P2X, 0,   1, 4'h0, 1'b1, 1'b0};
        tbl[12] = '{4'hF, CH_P2Y, 3,   1, 4'h1, 1'b0, 1'b1};
        tbl[13] = '{4'h4, CH_P2X, 3,   1, 4'hE, 1'b0, 1'b1};

        bus.adc_data = 4'h0;
        bus.adc_done = 1'b0;
        modelReset();

        // Reset state.
        repeat (3) @(negedge fastClock);
        check("reset/adc_sel", 32'(bus.adc_sel), 32'd0);
        check("reset/adc_start", {31'd0, bus.adc_start}, 32'd0);
        check("reset/results", 32'(results), 32'd0);
        check("reset/result_valid", 32'(result_valid), 32'd0);
        check("reset/scan_done", {31'd0, scan_done}, 32'd0);
        check("reset/timeout_err", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            ch_enable = tbl[i].en;
            convert($sformatf("row%0d", i), tbl[i].ch, tbl[i].delay, tbl[i].hold,
                    tbl[i].data, tbl[i].never, 1'b0, tbl[i].lastInPass);
            if (i == 4) begin
                check("pass1/results", 32'(results), 32'h8765);
                check("pass1/valid", 32'(result_valid), 32'hF);
            end
        end

        // err_clr drops the sticky flag.
        err_clr = 1'b1;
        @(negedge fastClock);
        err_clr = 1'b0;
        modErr = 1'b0;
        check("err_clr/timeout_err", {31'd0, timeout_err}, 32'd0);

        // Timeout and err_clr on the same edge: set wins.
        ch = modelNext(modPtr, ch_enable);
        convert("clr_vs_set", ch, 0, 1, 4'h0, 1'b1, 1'b1, modelIsLast(ch, ch_enable));

        // Nothing enabled: scheduler parks and never starts.
        ch_enable = 4'h0;
        startsBefore = nStartSeen;
        repeat (100) @(negedge fastClock);
        check("idle/no_start", 32'(nStartSeen - startsBefore), 32'd0);
        check("idle/sel_hold", 32'(bus.adc_sel), 32'(prevCh));
        gapValid = 1'b0;

        ch_enable = 4'hF;
        ch = modelNext(modPtr, ch_enable);
        convert("resume", ch, 3, 1, 4'hB, 1'b0, 1'b0, modelIsLast(ch, ch_enable));

        // Spurious done during SETTLE must not capture.
        repeat (10) @(negedge fastClock);
        bus.adc_data = 4'hF;
        bus.adc_done = 1'b1;
        @(negedge fastClock);
        bus.adc_done = 1'b0;
        bus.adc_data = 4'h0;
        @(negedge fastClock);
        check("spurious/results", 32'(results), 32'(packRes()));
        check("spurious/valid", 32'(result_valid), 32'(modValid));
        ch = modelNext(modPtr, ch_enable);
        convert("after_spurious", ch, 6, 1, 4'h3, 1'b0, 1'b0, modelIsLast(ch, ch_enable));

        // Randomized conversions against the model.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 2) == 0) ch_enable = 4'($urandom_range(1, 15));
            ch = modelNext(modPtr, ch_enable);
            nv = ($urandom_range(0, 11) == 0);
            dl = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(1, 40));
            convert($sformatf("rand%0d", r), ch, dl, 1, 4'($urandom), nv, 1'b0,
                    modelIsLast(ch, ch_enable));
        end

        // Reset in the middle of WAIT on P1 Y.
        ch_enable = 4'b0010;
        waited = 0;
        while (bus.adc_start !== 1'b1 && waited < 600) begin
            @(negedge fastClock);
            waited++;
        end
        check("rst_mid/start_seen", {31'd0, bus.adc_start}, 32'd1);
        expStarts++;
        check("rst_mid/sel", 32'(bus.adc_sel), 32'(CH_P1Y));
        repeat (3) @(negedge fastClock);
        reset = 1'b1;
        @(negedge fastClock);
        check("rst_mid/adc_start", {31'd0, bus.adc_start}, 32'd0);
        check("rst_mid/adc_sel", 32'(bus.adc_sel), 32'd0);
        check("rst_mid/results", 32'(results), 32'd0);
        check("rst_mid/valid", 32'(result_valid), 32'd0);
        check("rst_mid/scan_done", {31'd0, scan_done}, 32'd0);
        check("rst_mid/timeout_err", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        ch_enable = 4'hF;
        modelReset();
        gapValid = 1'b0;
        prevCh = 0;
        ch = modelNext(modPtr, ch_enable);
        check("rst_mid/restart_ch0", 32'(ch), 32'(CH_P1X));
        convert("after_reset", ch, 3, 1, 4'h9, 1'b0, 1'b0, modelIsLast(ch, ch_enable));

        // Pulse counts over the whole run.
        check("total/start_pulses", 32'(nStartSeen), 32'(expStarts));
        check("total/scan_done_pulses", 32'(nScanSeen), 32'(expScanDone));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
